// File: rtl/io_pad_bank.sv
// Bank of bidirectional pad channels: per-channel input/push-pull/open-drain drive plus a
// synchronised, glitch-filtered input path with edge detection and sticky interrupt status.
module io_pad_bank #(
    parameter int unsigned     N_CH        = 8,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     FILT_W      = 4,
    parameter logic [N_CH-1:0] RST_VAL     = {N_CH{1'b1}}
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [2*N_CH-1:0]   i_mode,
    input  logic [N_CH-1:0]     i_out,
    input  logic [FILT_W-1:0]   i_filt_len,
    input  logic [N_CH-1:0]     i_rise_en,
    input  logic [N_CH-1:0]     i_fall_en,
    input  logic [N_CH-1:0]     i_irq_clr,
    input  logic [N_CH-1:0]     pad_i,
    output logic [N_CH-1:0]     pad_o,
    output logic [N_CH-1:0]     pad_oe,
    output logic [N_CH-1:0]     o_in,
    output logic [N_CH-1:0]     o_rise,
    output logic [N_CH-1:0]     o_fall,
    output logic [N_CH-1:0]     o_irq_status,
    output logic                o_irq
);

    localparam int unsigned LAST_STAGE = SYNC_STAGES - 1;

    localparam logic [1:0] MODE_IN   = 2'b00;
    localparam logic [1:0] MODE_PP   = 2'b01;
    localparam logic [1:0] MODE_OD   = 2'b10;

    logic [N_CH-1:0]   r_pad_o;
    logic [N_CH-1:0]   r_pad_oe;
    logic [N_CH-1:0]   r_sync [SYNC_STAGES];
    logic [FILT_W-1:0] r_cnt  [N_CH];
    logic [N_CH-1:0]   r_in;
    logic [N_CH-1:0]   r_rise;
    logic [N_CH-1:0]   r_fall;
    logic [N_CH-1:0]   r_status;
    logic              r_irq;

    logic [N_CH-1:0]   w_pad_o_nxt;
    logic [N_CH-1:0]   w_pad_oe_nxt;
    logic [N_CH-1:0]   w_s;
    logic [N_CH-1:0]   w_in_nxt;
    logic [FILT_W-1:0] w_cnt_nxt [N_CH];

    // Drive decode; reserved mode 11 behaves as input.
    always_comb begin
        w_pad_o_nxt  = '0;
        w_pad_oe_nxt = '0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            unique case (i_mode[2*ch +: 2])
                MODE_PP: begin
                    w_pad_oe_nxt[ch] = 1'b1;
                    w_pad_o_nxt[ch]  = i_out[ch];
                end
                MODE_OD: begin
                    w_pad_oe_nxt[ch] = ~i_out[ch];
                    w_pad_o_nxt[ch]  = 1'b0;
                end
                MODE_IN: begin
                    w_pad_oe_nxt[ch] = 1'b0;
                    w_pad_o_nxt[ch]  = 1'b0;
                end
                default: begin
                    w_pad_oe_nxt[ch] = 1'b0;
                    w_pad_o_nxt[ch]  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pad_o  <= '0;
            r_pad_oe <= '0;
        end else begin
            r_pad_o  <= w_pad_o_nxt;
            r_pad_oe <= w_pad_oe_nxt;
        end
    end

    // Input synchroniser chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= RST_VAL;
            end
        end else begin
            r_sync[0] <= pad_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[LAST_STAGE];

    // Glitch filter: a counter at or beyond the length (length lowered mid-count) commits the change.
    always_comb begin
        w_in_nxt = r_in;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            w_cnt_nxt[ch] = '0;
            if (w_s[ch] != r_in[ch]) begin
                if (r_cnt[ch] >= i_filt_len) begin
                    w_in_nxt[ch] = w_s[ch];
                end else begin
                    w_cnt_nxt[ch] = r_cnt[ch] + FILT_W'(1);
                end
            end
        end
    end

    // Edge pulses are registered alongside the filtered value so they align with the new o_in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                r_cnt[ch] <= '0;
            end
            r_in     <= RST_VAL;
            r_rise   <= '0;
            r_fall   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                r_cnt[ch] <= w_cnt_nxt[ch];
            end
            r_in     <= w_in_nxt;
            r_rise   <= w_in_nxt & ~r_in;
            r_fall   <= ~w_in_nxt & r_in;
            r_status <= (r_status & ~i_irq_clr) | (r_rise & i_rise_en) | (r_fall & i_fall_en);
            r_irq    <= |r_status;
        end
    end

    assign pad_o        = r_pad_o;
    assign pad_oe       = r_pad_oe;
    assign o_in         = r_in;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_irq_status = r_status;
    assign o_irq        = r_irq;

endmodule

// File: tb/tb_io_pad_bank.sv
// Scoreboard bench for io_pad_bank: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_io_pad_bank;

    localparam int S_PO   = 0;
    localparam int S_OE   = 1;
    localparam int S_IN   = 2;
    localparam int S_RISE = 3;
    localparam int S_FALL = 4;
    localparam int S_STAT = 5;
    localparam int S_IRQ  = 6;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] mask;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_mode;
    logic [7:0]  i_out;
    logic [3:0]  i_filt_len;
    logic [7:0]  i_rise_en;
    logic [7:0]  i_fall_en;
    logic [7:0]  i_irq_clr;
    logic [7:0]  pad_i;
    logic [7:0]  pad_o;
    logic [7:0]  pad_oe;
    logic [7:0]  o_in;
    logic [7:0]  o_rise;
    logic [7:0]  o_fall;
    logic [7:0]  o_irq_status;
    logic        o_irq;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    io_pad_bank dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_mode       (i_mode),
        .i_out        (i_out),
        .i_filt_len   (i_filt_len),
        .i_rise_en    (i_rise_en),
        .i_fall_en    (i_fall_en),
        .i_irq_clr    (i_irq_clr),
        .pad_i        (pad_i),
        .pad_o        (pad_o),
        .pad_oe       (pad_oe),
        .o_in         (o_in),
        .o_rise       (o_rise),
        .o_fall       (o_fall),
        .o_irq_status (o_irq_status),
        .o_irq        (o_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            S_PO:    return pad_o;
            S_OE:    return pad_oe;
            S_IN:    return o_in;
            S_RISE:  return o_rise;
            S_FALL:  return o_fall;
            S_STAT:  return o_irq_status;
            default: return {7'b0, o_irq};
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        int i;
        logic [7:0] got;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                got = actual(q[i].sel);
                n_checks++;
                if ((got & q[i].mask) !== (q[i].val & q[i].mask)) begin
                    n_errors++;
                    $display("FAIL %s cyc %0d got %h exp %h mask %h",
                             q[i].name, cyc, got & q[i].mask, q[i].val & q[i].mask, q[i].mask);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s missed cyc %0d", q[i].name, q[i].cyc);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input int sel, input logic [7:0] mask,
                             input logic [7:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_mode     = '0;
        i_out      = '0;
        i_filt_len = '0;
        i_rise_en  = '0;
        i_fall_en  = '0;
        i_irq_clr  = '0;
        pad_i      = 8'hFF;
        tick(3);

        // reset state, then quiet release with pad at idle-high
        expect_at(0, S_PO,   8'hFF, 8'h00, "rst_pad_o");
        expect_at(0, S_OE,   8'hFF, 8'h00, "rst_pad_oe");
        expect_at(0, S_IN,   8'hFF, 8'hFF, "rst_o_in");
        expect_at(0, S_RISE, 8'hFF, 8'h00, "rst_rise");
        expect_at(0, S_FALL, 8'hFF, 8'h00, "rst_fall");
        expect_at(0, S_STAT, 8'hFF, 8'h00, "rst_status");
        expect_at(0, S_IRQ,  8'h01, 8'h00, "rst_irq");
        i_rst = 1'b0;
        for (int d = 1; d <= 20; d++) begin
            expect_at(d, S_RISE, 8'hFF, 8'h00, "rel_rise");
            expect_at(d, S_FALL, 8'hFF, 8'h00, "rel_fall");
            expect_at(d, S_IN,   8'hFF, 8'hFF, "rel_o_in");
            expect_at(d, S_OE,   8'hFF, 8'h00, "rel_pad_oe");
        end
        tick(21);

        // output modes
        i_mode = 16'h0001; i_out = 8'h01;
        expect_at(0, S_OE, 8'h01, 8'h00, "pp_latency");
        expect_at(1, S_OE, 8'h01, 8'h01, "pp_oe");
        expect_at(1, S_PO, 8'h01, 8'h01, "pp_o");
        tick(2);
        i_mode = 16'h0009; i_out = 8'h01;
        expect_at(1, S_OE, 8'h03, 8'h03, "od_low_oe");
        expect_at(1, S_PO, 8'h03, 8'h01, "od_low_o");
        tick(2);
        i_out = 8'h03;
        expect_at(1, S_OE, 8'h03, 8'h01, "od_rel_oe");
        expect_at(1, S_PO, 8'h03, 8'h01, "od_rel_o");
        tick(2);
        i_mode = 16'h000B;
        expect_at(1, S_OE, 8'h03, 8'h00, "rsvd_oe");
        expect_at(1, S_PO, 8'h03, 8'h00, "rsvd_o");
        tick(2);
        i_mode = '0; i_out = '0;
        tick(2);

        // L=0: filtered value follows sync output one cycle later
        pad_i[5] = 1'b0;
        expect_at(2, S_IN,   8'h20, 8'h20, "l0_in_hold");
        expect_at(3, S_IN,   8'h20, 8'h00, "l0_in_fall");
        expect_at(3, S_FALL, 8'h20, 8'h20, "l0_fall");
        expect_at(4, S_FALL, 8'h20, 8'h00, "l0_fall_end");
        tick(5);
        pad_i[5] = 1'b1;
        expect_at(2, S_IN,   8'h20, 8'h00, "l0_in_low");
        expect_at(3, S_IN,   8'h20, 8'h20, "l0_in_rise");
        expect_at(3, S_RISE, 8'h20, 8'h20, "l0_rise");
        expect_at(4, S_RISE, 8'h20, 8'h00, "l0_rise_end");
        tick(6);

        // L=3: 3-cycle glitch dropped, 4-cycle pulse passes
        i_filt_len = 4'd3;
        tick(1);
        pad_i[2] = 1'b0;
        for (int d = 0; d <= 12; d++) begin
            expect_at(d, S_IN,   8'h04, 8'h04, "glitch_in");
            expect_at(d, S_FALL, 8'h04, 8'h00, "glitch_fall");
        end
        tick(3);
        pad_i[2] = 1'b1;
        tick(12);
        pad_i[2] = 1'b0;
        expect_at(5,  S_IN,   8'h04, 8'h04, "f4_in_hold");
        expect_at(6,  S_IN,   8'h04, 8'h00, "f4_in_low");
        expect_at(5,  S_FALL, 8'h04, 8'h00, "f4_fall_pre");
        expect_at(6,  S_FALL, 8'h04, 8'h04, "f4_fall");
        expect_at(7,  S_FALL, 8'h04, 8'h00, "f4_fall_end");
        expect_at(8,  S_STAT, 8'h04, 8'h00, "f4_nostat");
        expect_at(9,  S_IN,   8'h04, 8'h00, "r4_in_low");
        expect_at(10, S_IN,   8'h04, 8'h04, "r4_in_high");
        expect_at(10, S_RISE, 8'h04, 8'h04, "r4_rise");
        expect_at(11, S_RISE, 8'h04, 8'h00, "r4_rise_end");
        expect_at(11, S_STAT, 8'h04, 8'h00, "rise_dis_stat");
        expect_at(12, S_STAT, 8'h04, 8'h00, "rise_dis_stat2");
        tick(4);
        pad_i[2] = 1'b1;
        tick(14);

        // fall status, irq, set-wins-over-clear, clear
        i_fall_en = 8'h04;
        tick(1);
        pad_i[2] = 1'b0;
        expect_at(6, S_FALL, 8'h04, 8'h04, "st_fall");
        expect_at(6, S_STAT, 8'h04, 8'h00, "st_pre");
        expect_at(7, S_STAT, 8'h04, 8'h04, "st_set");
        expect_at(7, S_IRQ,  8'h01, 8'h00, "irq_pre");
        expect_at(8, S_IRQ,  8'h01, 8'h01, "irq_set");
        tick(10);
        pad_i[2] = 1'b1;
        expect_at(5, S_IN,   8'h04, 8'h00, "st_in_low");
        expect_at(6, S_IN,   8'h04, 8'h04, "st_in_high");
        expect_at(6, S_STAT, 8'h04, 8'h04, "st_sticky");
        tick(10);
        pad_i[2] = 1'b0;
        expect_at(6, S_FALL, 8'h04, 8'h04, "clr_fall");
        expect_at(7, S_STAT, 8'h04, 8'h04, "set_wins");
        tick(6);
        i_irq_clr = 8'h04;
        tick(1);
        i_irq_clr = 8'h00;
        tick(3);
        i_irq_clr = 8'h04;
        expect_at(1, S_STAT, 8'h04, 8'h00, "clr_stat");
        expect_at(1, S_IRQ,  8'h01, 8'h01, "clr_irq_lag");
        expect_at(2, S_IRQ,  8'h01, 8'h00, "clr_irq");
        tick(1);
        i_irq_clr = 8'h00;
        tick(5);

        // reset during filter count
        pad_i[2] = 1'b1;
        tick(4);
        i_rst = 1'b1;
        expect_at(1, S_IN,   8'hFF, 8'hFF, "mrst_in");
        expect_at(1, S_STAT, 8'hFF, 8'h00, "mrst_stat");
        expect_at(1, S_RISE, 8'hFF, 8'h00, "mrst_rise");
        expect_at(1, S_FALL, 8'hFF, 8'h00, "mrst_fall");
        expect_at(1, S_OE,   8'hFF, 8'h00, "mrst_oe");
        tick(1);
        i_rst = 1'b0;
        for (int d = 0; d <= 10; d++) begin
            expect_at(d, S_RISE, 8'h04, 8'h00, "mrst_no_rise");
            expect_at(d, S_IN,   8'h04, 8'h04, "mrst_in_hold");
        end
        tick(12);

        // reset after edge, before status is set
        pad_i[2] = 1'b0;
        tick(6);
        expect_at(0, S_FALL, 8'h04, 8'h04, "erst_fall");
        i_rst = 1'b1;
        expect_at(1, S_STAT, 8'h04, 8'h00, "erst_stat");
        expect_at(1, S_IN,   8'h04, 8'h04, "erst_in");
        expect_at(1, S_FALL, 8'h04, 8'h00, "erst_fall_clr");
        expect_at(2, S_STAT, 8'h04, 8'h00, "erst_stat2");
        expect_at(2, S_IRQ,  8'h01, 8'h00, "erst_irq");
        tick(1);
        i_rst = 1'b0;
        expect_at(5, S_STAT, 8'h04, 8'h00, "erst_refill_pre");
        expect_at(6, S_FALL, 8'h04, 8'h04, "erst_refill_fall");
        expect_at(7, S_STAT, 8'h04, 8'h04, "erst_refill_stat");
        tick(10);

        tick(3);
        while (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s never checked (cyc %0d)", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
